// File: rtl/cntr_arbiter.sv
// Round-robin arbiter sharing one up/down/load counter between requesters A and B.
// Optional saturation guard (adds err port) is enabled by defining CNTR_ARB_SAT_GUARD_EN.
module cntr_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         req_a,
  input  logic [1:0]   op_a,
  input  logic [W-1:0] data_a,
  output logic         gnt_a,
  output logic         done_a,
  input  logic         req_b,
  input  logic [1:0]   op_b,
  input  logic [W-1:0] data_b,
  output logic         gnt_b,
  output logic         done_b,
  output logic [W-1:0] rsp_q,
  input  logic [W-1:0] cnt_q,
  output logic [1:0]   cnt_func,
  output logic [W-1:0] cnt_load,
  output logic         cnt_set_max,
  output logic         cnt_aclr
`ifdef CNTR_ARB_SAT_GUARD_EN
  ,
  output logic         err
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]   state_r;
  logic         rr_last_r;  // 0 = A served last, 1 = B served last
  logic         eff_a_s;
  logic         eff_b_s;
  logic         win_a_s;
  logic         win_b_s;
  logic [1:0]   sel_op_s;
  logic [W-1:0] sel_data_s;
  logic         blocked_s;

`ifdef CNTR_ARB_SAT_GUARD_EN
  logic         blk_r;

  function automatic logic sat_block(input logic [1:0] op, input logic [W-1:0] q);
    case (op)
      2'b00:   sat_block = (q == {W{1'b1}});
      2'b01:   sat_block = (q == {W{1'b0}});
      default: sat_block = 1'b0;
    endcase
  endfunction
`endif

  // Arbitration: a requester in its own done cycle is ignored; ties go to the one not served last
  always_comb begin
    eff_a_s    = req_a & ~done_a;
    eff_b_s    = req_b & ~done_b;
    win_a_s    = eff_a_s & (~eff_b_s | rr_last_r);
    win_b_s    = eff_b_s & (~eff_a_s | ~rr_last_r);
    sel_op_s   = 2'b11;
    sel_data_s = {W{1'b0}};
    if (win_a_s) begin
      sel_op_s   = op_a;
      sel_data_s = data_a;
    end else begin
      sel_op_s   = op_b;
      sel_data_s = data_b;
    end
    // The counter only moves under our control, so its IDLE value is the value seen in ISSUE
`ifdef CNTR_ARB_SAT_GUARD_EN
    blocked_s = sat_block(sel_op_s, cnt_q);
`else
    blocked_s = 1'b0;
`endif
  end

  // Transaction FSM and all registered counter-control / response outputs
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_r     <= IDLE;
      rr_last_r   <= 1'b1;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      done_a      <= 1'b0;
      done_b      <= 1'b0;
      rsp_q       <= {W{1'b0}};
      cnt_func    <= 2'b11;
      cnt_load    <= {W{1'b0}};
      cnt_set_max <= 1'b0;
      cnt_aclr    <= 1'b1;
`ifdef CNTR_ARB_SAT_GUARD_EN
      blk_r       <= 1'b0;
      err         <= 1'b0;
`endif
    end else begin
      cnt_aclr <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
`ifdef CNTR_ARB_SAT_GUARD_EN
      err      <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (win_a_s || win_b_s) begin
            gnt_a     <= win_a_s;
            gnt_b     <= win_b_s;
            rr_last_r <= win_b_s;
            state_r   <= ISSUE;
            if ((sel_op_s == 2'b11) || blocked_s) begin
              cnt_func <= 2'b11;
            end else begin
              cnt_func <= sel_op_s;
            end
            cnt_set_max <= (sel_op_s == 2'b11);
            if (sel_op_s == 2'b10) begin
              cnt_load <= sel_data_s;
            end else begin
              cnt_load <= cnt_load;
            end
`ifdef CNTR_ARB_SAT_GUARD_EN
            blk_r <= blocked_s;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          cnt_func    <= 2'b11;
          cnt_set_max <= 1'b0;
          state_r     <= CAPTURE;
        end
        CAPTURE: begin
          rsp_q   <= cnt_q;
          done_a  <= gnt_a;
          done_b  <= gnt_b;
          gnt_a   <= 1'b0;
          gnt_b   <= 1'b0;
          state_r <= IDLE;
`ifdef CNTR_ARB_SAT_GUARD_EN
          err     <= blk_r;
`endif
        end
        default: begin
          cnt_func    <= 2'b11;
          cnt_set_max <= 1'b0;
          gnt_a       <= 1'b0;
          gnt_b       <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
